// File: rtl/core_issue_ctrl_if.sv
// ID/EX issue-control bus for core_issue_ctrl.
// The master modport is the pipeline side and the slave modport is the controller.
interface core_issue_ctrl_if;
  logic        id_valid_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic [4:0]  id_rd_addr_i;
  logic        id_uses_rs1_i;
  logic        id_uses_rs2_i;
  logic        id_writes_rd_i;
  logic        id_is_load_i;
  logic        id_is_muldiv_i;
  logic        ex_flush_i;
  logic        lsu_wb_valid_i;
  logic [4:0]  lsu_wb_rd_i;
  logic        md_done_i;
  logic [4:0]  md_wb_rd_i;
  logic        issue_o;
  logic        stall_o;
  logic        md_start_o;
  logic        md_busy_o;
  logic [31:0] scoreboard_o;

  modport master (
    output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
           id_uses_rs1_i, id_uses_rs2_i, id_writes_rd_i, id_is_load_i,
           id_is_muldiv_i, ex_flush_i, lsu_wb_valid_i, lsu_wb_rd_i,
           md_done_i, md_wb_rd_i,
    input  issue_o, stall_o, md_start_o, md_busy_o, scoreboard_o
  );

  modport slave (
    input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
           id_uses_rs1_i, id_uses_rs2_i, id_writes_rd_i, id_is_load_i,
           id_is_muldiv_i, ex_flush_i, lsu_wb_valid_i, lsu_wb_rd_i,
           md_done_i, md_wb_rd_i,
    output issue_o, stall_o, md_start_o, md_busy_o, scoreboard_o
  );
endinterface

// File: rtl/core_issue_ctrl.sv
// ID->EX issue/hazard controller: register scoreboard, load counter, mul/div sequencer.
// Optional CORE_WB_BYPASS_EN lets a consumer issue in the same cycle as its producer's writeback.
module core_issue_ctrl #(
  parameter int unsigned MAX_LOADS = 4
) (
  input logic              clk_i,
  input logic              arst_i,
  core_issue_ctrl_if.slave bus
);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } md_state_e;

  localparam logic [3:0] MaxCnt = 4'(MAX_LOADS);

  md_state_e   md_state_q, md_state_d;
  logic [31:0] sb_q, sb_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [31:0] clr_vec;
  logic [31:0] sb_view;
  logic        md_blocked;
  logic        raw1, raw2, waw, ldfull, mdbusy, hazard;
  logic        go, issue, stall, md_start;
  logic        ld_inc, ld_dec;

  always_comb begin
    clr_vec = '0;
    if (bus.lsu_wb_valid_i) clr_vec[bus.lsu_wb_rd_i] = 1'b1;
    if (bus.md_done_i)      clr_vec[bus.md_wb_rd_i]  = 1'b1;
  end

`ifdef CORE_WB_BYPASS_EN
  assign sb_view    = sb_q & ~clr_vec;
  assign md_blocked = (md_state_q == ST_BUSY) & ~bus.md_done_i;
`else
  assign sb_view    = sb_q;
  assign md_blocked = (md_state_q == ST_BUSY);
`endif

  always_comb begin
    raw1   = bus.id_uses_rs1_i  & sb_view[bus.id_rs1_addr_i];
    raw2   = bus.id_uses_rs2_i  & sb_view[bus.id_rs2_addr_i];
    waw    = bus.id_writes_rd_i & sb_view[bus.id_rd_addr_i];
    ldfull = bus.id_is_load_i   & (cnt_q == MaxCnt);
    mdbusy = bus.id_is_muldiv_i & md_blocked;
    hazard = raw1 | raw2 | waw | ldfull | mdbusy;
    go       = bus.id_valid_i & ~bus.ex_flush_i;
    stall    = go & hazard;
    issue    = go & ~hazard;
    md_start = issue & bus.id_is_muldiv_i;
  end

  // State paths stay free of arst_i; only the visible pulses are gated during reset.
  assign bus.issue_o      = issue & ~arst_i;
  assign bus.stall_o      = stall & ~arst_i;
  assign bus.md_start_o   = md_start & ~arst_i;
  assign bus.md_busy_o    = (md_state_q == ST_BUSY);
  assign bus.scoreboard_o = sb_q;

  // Clears applied before the set so a same-cycle set on the same register wins.
  always_comb begin
    sb_d = sb_q & ~clr_vec;
    if (issue && bus.id_writes_rd_i && (bus.id_is_load_i || bus.id_is_muldiv_i)
        && (bus.id_rd_addr_i != 5'd0)) begin
      sb_d[bus.id_rd_addr_i] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_comb begin
    ld_inc = issue & bus.id_is_load_i;
    ld_dec = bus.lsu_wb_valid_i & (cnt_q != '0);
    cnt_d  = cnt_q;
    case ({ld_inc, ld_dec})
      2'b10:   if (cnt_q != MaxCnt) cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    md_state_d = md_state_q;
    case (md_state_q)
      ST_IDLE: if (md_start) md_state_d = ST_BUSY;
      ST_BUSY: begin
        if (md_start)           md_state_d = ST_BUSY;
        else if (bus.md_done_i) md_state_d = ST_IDLE;
      end
      default: md_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sb_q       <= '0;
      cnt_q      <= '0;
      md_state_q <= ST_IDLE;
    end else begin
      sb_q       <= sb_d;
      cnt_q      <= cnt_d;
      md_state_q <= md_state_d;
    end
  end

`ifndef SYNTHESIS
  wb_without_load : assert property (@(posedge clk_i) disable iff (arst_i)
    bus.lsu_wb_valid_i |-> (cnt_q != '0));
`endif

endmodule

// File: tb/tb_core_issue_ctrl.sv
// Directed bench for core_issue_ctrl: load-use, load fill, mul/div, flush, x0/WAW, async reset.
// Expected timing follows CORE_WB_BYPASS_EN when the bench is built with it.
module tb_core_issue_ctrl;
  logic clk;
  logic rst;
  int unsigned n_vec;
  int unsigned n_err;

  core_issue_ctrl_if bus ();

  core_issue_ctrl #(.MAX_LOADS(4)) dut (
    .clk_i  (clk),
    .arst_i (rst),
    .bus    (bus.slave)
  );

`ifdef CORE_WB_BYPASS_EN
  localparam int LU_ISSUE  = 3;
  localparam int WAW_ISSUE = 2;
  localparam bit BYP       = 1'b1;
`else
  localparam int LU_ISSUE  = 4;
  localparam int WAW_ISSUE = 3;
  localparam bit BYP       = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_id();
    bus.id_valid_i     = 1'b0;
    bus.id_rs1_addr_i  = '0;
    bus.id_rs2_addr_i  = '0;
    bus.id_rd_addr_i   = '0;
    bus.id_uses_rs1_i  = 1'b0;
    bus.id_uses_rs2_i  = 1'b0;
    bus.id_writes_rd_i = 1'b0;
    bus.id_is_load_i   = 1'b0;
    bus.id_is_muldiv_i = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic w,
                        input logic ld, input logic md);
    bus.id_valid_i     = 1'b1;
    bus.id_rs1_addr_i  = rs1;
    bus.id_rs2_addr_i  = rs2;
    bus.id_rd_addr_i   = rd;
    bus.id_uses_rs1_i  = u1;
    bus.id_uses_rs2_i  = u2;
    bus.id_writes_rd_i = w;
    bus.id_is_load_i   = ld;
    bus.id_is_muldiv_i = md;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_id(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    n_vec++; if (bus.issue_o !== 1'b0) begin n_err++; $display("FAIL rst_issue got=%b exp=0", bus.issue_o); end
    n_vec++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL rst_stall got=%b exp=0", bus.stall_o); end
    n_vec++; if (bus.md_start_o !== 1'b0) begin n_err++; $display("FAIL rst_start got=%b exp=0", bus.md_start_o); end
    tick();
    n_vec++; if (bus.md_busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", bus.md_busy_o); end
    n_vec++; if (bus.scoreboard_o !== 32'h0) begin n_err++; $display("FAIL rst_sb got=%h exp=0", bus.scoreboard_o); end
    n_vec++; if (dut.cnt_q !== 4'd0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", dut.cnt_q); end
    rst = 1'b0;
    clr_id();
    tick();
  endtask

  task automatic test_load_use();
    set_id(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    n_vec++; if (bus.issue_o !== 1'b1) begin n_err++; $display("FAIL lu_lw_issue got=%b exp=1", bus.issue_o); end
    tick();
    n_vec++; if (bus.scoreboard_o !== 32'h20) begin n_err++; $display("FAIL lu_sb got=%h exp=00000020", bus.scoreboard_o); end
    set_id(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= LU_ISSUE; c++) begin
      bus.lsu_wb_valid_i = (c == 3);
      bus.lsu_wb_rd_i    = 5'd5;
      #1;
      n_vec++; if (bus.issue_o !== (c == LU_ISSUE)) begin n_err++; $display("FAIL lu_issue_c%0d got=%b exp=%b", c, bus.issue_o, (c == LU_ISSUE)); end
      n_vec++; if (bus.stall_o !== (c != LU_ISSUE)) begin n_err++; $display("FAIL lu_stall_c%0d got=%b exp=%b", c, bus.stall_o, (c != LU_ISSUE)); end
      tick();
    end
    bus.lsu_wb_valid_i = 1'b0;
    clr_id();
    #1;
    n_vec++; if (bus.scoreboard_o !== 32'h0) begin n_err++; $display("FAIL lu_sb_end got=%h exp=0", bus.scoreboard_o); end
    n_vec++; if (dut.cnt_q !== 4'd0) begin n_err++; $display("FAIL lu_cnt_end got=%0d exp=0", dut.cnt_q); end
    tick();
  endtask

  task automatic test_load_fill();
    for (int k = 0; k < 4; k++) begin
      set_id(5'd1, 5'd0, 5'(10 + k), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      n_vec++; if (bus.issue_o !== 1'b1) begin n_err++; $display("FAIL fill_issue_k%0d got=%b exp=1", k, bus.issue_o); end
      tick();
    end
    set_id(5'd1, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    n_vec++; if (bus.stall_o !== 1'b1) begin n_err++; $display("FAIL fill_5th_stall got=%b exp=1", bus.stall_o); end
    n_vec++; if (dut.cnt_q !== 4'd4) begin n_err++; $display("FAIL fill_cnt_full got=%0d exp=4", dut.cnt_q); end
    tick();
    bus.lsu_wb_valid_i = 1'b1;
    bus.lsu_wb_rd_i    = 5'd10;
    #1;
    n_vec++; if (bus.stall_o !== 1'b1) begin n_err++; $display("FAIL fill_wb_stall got=%b exp=1", bus.stall_o); end
    tick();
    bus.lsu_wb_valid_i = 1'b0;
    #1;
    n_vec++; if (dut.cnt_q !== 4'd3) begin n_err++; $display("FAIL fill_cnt_after_wb got=%0d exp=3", dut.cnt_q); end
    n_vec++; if (bus.issue_o !== 1'b1) begin n_err++; $display("FAIL fill_5th_issue got=%b exp=1", bus.issue_o); end
    tick();
    clr_id();
    n_vec++; if (dut.cnt_q !== 4'd4) begin n_err++; $display("FAIL fill_cnt_refull got=%0d exp=4", dut.cnt_q); end
    n_vec++; if (bus.scoreboard_o !== 32'h7800) begin n_err++; $display("FAIL fill_sb got=%h exp=00007800", bus.scoreboard_o); end
    for (int r = 11; r <= 14; r++) begin
      bus.lsu_wb_valid_i = 1'b1;
      bus.lsu_wb_rd_i    = 5'(r);
      tick();
    end
    bus.lsu_wb_valid_i = 1'b0;
    n_vec++; if (dut.cnt_q !== 4'd0) begin n_err++; $display("FAIL fill_cnt_drain got=%0d exp=0", dut.cnt_q); end
    n_vec++; if (bus.scoreboard_o !== 32'h0) begin n_err++; $display("FAIL fill_sb_drain got=%h exp=0", bus.scoreboard_o); end
    tick();
  endtask

  task automatic test_muldiv();
    set_id(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    n_vec++; if (bus.issue_o !== 1'b1) begin n_err++; $display("FAIL md_mul_issue got=%b exp=1", bus.issue_o); end
    n_vec++; if (bus.md_start_o !== 1'b1) begin n_err++; $display("FAIL md_mul_start got=%b exp=1", bus.md_start_o); end
    n_vec++; if (bus.md_busy_o !== 1'b0) begin n_err++; $display("FAIL md_busy_pre got=%b exp=0", bus.md_busy_o); end
    tick();
    n_vec++; if (bus.scoreboard_o !== 32'h80) begin n_err++; $display("FAIL md_sb7 got=%h exp=00000080", bus.scoreboard_o); end
    set_id(5'd3, 5'd4, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      bus.md_done_i  = (c == 10);
      bus.md_wb_rd_i = 5'd7;
      #1;
      n_vec++; if (bus.md_busy_o !== 1'b1) begin n_err++; $display("FAIL md_busy_c%0d got=%b exp=1", c, bus.md_busy_o); end
      n_vec++; if (bus.issue_o !== (BYP && c == 10)) begin n_err++; $display("FAIL md_div_issue_c%0d got=%b exp=%b", c, bus.issue_o, (BYP && c == 10)); end
      n_vec++; if (bus.md_start_o !== (BYP && c == 10)) begin n_err++; $display("FAIL md_div_start_c%0d got=%b exp=%b", c, bus.md_start_o, (BYP && c == 10)); end
      tick();
    end
    bus.md_done_i = 1'b0;
`ifndef CORE_WB_BYPASS_EN
    #1;
    n_vec++; if (bus.md_busy_o !== 1'b0) begin n_err++; $display("FAIL md_idle_after_done got=%b exp=0", bus.md_busy_o); end
    n_vec++; if (bus.scoreboard_o !== 32'h0) begin n_err++; $display("FAIL md_sb7_clear got=%h exp=0", bus.scoreboard_o); end
    n_vec++; if (bus.issue_o !== 1'b1) begin n_err++; $display("FAIL md_div_issue got=%b exp=1", bus.issue_o); end
    n_vec++; if (bus.md_start_o !== 1'b1) begin n_err++; $display("FAIL md_div_start got=%b exp=1", bus.md_start_o); end
    tick();
`endif
    clr_id();
    #1;
    n_vec++; if (bus.md_busy_o !== 1'b1) begin n_err++; $display("FAIL md_div_busy got=%b exp=1", bus.md_busy_o); end
    n_vec++; if (bus.scoreboard_o !== 32'h100) begin n_err++; $display("FAIL md_sb8 got=%h exp=00000100", bus.scoreboard_o); end
    bus.md_done_i  = 1'b1;
    bus.md_wb_rd_i = 5'd8;
    tick();
    bus.md_done_i = 1'b0;
    n_vec++; if (bus.md_busy_o !== 1'b0) begin n_err++; $display("FAIL md_div_done_busy got=%b exp=0", bus.md_busy_o); end
    n_vec++; if (bus.scoreboard_o !== 32'h0) begin n_err++; $display("FAIL md_sb_end got=%h exp=0", bus.scoreboard_o); end
    tick();
  endtask

  task automatic test_flush();
    set_id(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    bus.ex_flush_i = 1'b1;
    set_id(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    n_vec++; if (bus.issue_o !== 1'b0) begin n_err++; $display("FAIL fl_issue got=%b exp=0", bus.issue_o); end
    n_vec++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL fl_stall got=%b exp=0", bus.stall_o); end
    tick();
    set_id(5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    n_vec++; if (bus.md_start_o !== 1'b0) begin n_err++; $display("FAIL fl_md_start got=%b exp=0", bus.md_start_o); end
    tick();
    bus.ex_flush_i = 1'b0;
    clr_id();
    n_vec++; if (bus.scoreboard_o !== 32'h20) begin n_err++; $display("FAIL fl_sb got=%h exp=00000020", bus.scoreboard_o); end
    n_vec++; if (dut.cnt_q !== 4'd1) begin n_err++; $display("FAIL fl_cnt got=%0d exp=1", dut.cnt_q); end
    n_vec++; if (bus.md_busy_o !== 1'b0) begin n_err++; $display("FAIL fl_busy got=%b exp=0", bus.md_busy_o); end
    bus.lsu_wb_valid_i = 1'b1;
    bus.lsu_wb_rd_i    = 5'd5;
    tick();
    bus.lsu_wb_valid_i = 1'b0;
    n_vec++; if (bus.scoreboard_o !== 32'h0) begin n_err++; $display("FAIL fl_sb_end got=%h exp=0", bus.scoreboard_o); end
    tick();
  endtask

  task automatic test_x0_waw();
    set_id(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    n_vec++; if (bus.issue_o !== 1'b1) begin n_err++; $display("FAIL x0_issue got=%b exp=1", bus.issue_o); end
    tick();
    clr_id();
    n_vec++; if (bus.scoreboard_o !== 32'h0) begin n_err++; $display("FAIL x0_sb got=%h exp=0", bus.scoreboard_o); end
    n_vec++; if (dut.cnt_q !== 4'd1) begin n_err++; $display("FAIL x0_cnt got=%0d exp=1", dut.cnt_q); end
    bus.lsu_wb_valid_i = 1'b1;
    bus.lsu_wb_rd_i    = 5'd0;
    tick();
    bus.lsu_wb_valid_i = 1'b0;
    set_id(5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    for (int c = 1; c <= WAW_ISSUE; c++) begin
      bus.lsu_wb_valid_i = (c == 2);
      bus.lsu_wb_rd_i    = 5'd9;
      #1;
      n_vec++; if (bus.issue_o !== (c == WAW_ISSUE)) begin n_err++; $display("FAIL waw_issue_c%0d got=%b exp=%b", c, bus.issue_o, (c == WAW_ISSUE)); end
      n_vec++; if (bus.stall_o !== (c != WAW_ISSUE)) begin n_err++; $display("FAIL waw_stall_c%0d got=%b exp=%b", c, bus.stall_o, (c != WAW_ISSUE)); end
      tick();
    end
    bus.lsu_wb_valid_i = 1'b0;
    clr_id();
    n_vec++; if (bus.scoreboard_o !== 32'h200) begin n_err++; $display("FAIL waw_sb got=%h exp=00000200", bus.scoreboard_o); end
    n_vec++; if (dut.cnt_q !== 4'd1) begin n_err++; $display("FAIL waw_cnt got=%0d exp=1", dut.cnt_q); end
    bus.lsu_wb_valid_i = 1'b1;
    bus.lsu_wb_rd_i    = 5'd9;
    tick();
    bus.lsu_wb_valid_i = 1'b0;
    n_vec++; if (dut.cnt_q !== 4'd0) begin n_err++; $display("FAIL waw_cnt_end got=%0d exp=0", dut.cnt_q); end
    tick();
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      set_id(5'd1, 5'd0, 5'(20 + k), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    set_id(5'd1, 5'd2, 5'd23, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    n_vec++; if (dut.cnt_q !== 4'd3) begin n_err++; $display("FAIL ar_cnt_pre got=%0d exp=3", dut.cnt_q); end
    n_vec++; if (bus.md_busy_o !== 1'b1) begin n_err++; $display("FAIL ar_busy_pre got=%b exp=1", bus.md_busy_o); end
    n_vec++; if (bus.scoreboard_o !== 32'h00F0_0000) begin n_err++; $display("FAIL ar_sb_pre got=%h exp=00f00000", bus.scoreboard_o); end
    set_id(5'd1, 5'd0, 5'd24, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    n_vec++; if (bus.issue_o !== 1'b1) begin n_err++; $display("FAIL ar_issue_pre got=%b exp=1", bus.issue_o); end
    rst = 1'b1;
    #1;
    n_vec++; if (bus.issue_o !== 1'b0) begin n_err++; $display("FAIL ar_issue got=%b exp=0", bus.issue_o); end
    n_vec++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL ar_stall got=%b exp=0", bus.stall_o); end
    n_vec++; if (bus.md_busy_o !== 1'b0) begin n_err++; $display("FAIL ar_busy got=%b exp=0", bus.md_busy_o); end
    n_vec++; if (bus.scoreboard_o !== 32'h0) begin n_err++; $display("FAIL ar_sb got=%h exp=0", bus.scoreboard_o); end
    n_vec++; if (dut.cnt_q !== 4'd0) begin n_err++; $display("FAIL ar_cnt got=%0d exp=0", dut.cnt_q); end
    tick();
    rst = 1'b0;
    clr_id();
    bus.md_done_i  = 1'b1;
    bus.md_wb_rd_i = 5'd23;
    tick();
    bus.md_done_i = 1'b0;
    n_vec++; if (bus.md_busy_o !== 1'b0) begin n_err++; $display("FAIL ar_busy_post got=%b exp=0", bus.md_busy_o); end
    n_vec++; if (bus.scoreboard_o !== 32'h0) begin n_err++; $display("FAIL ar_sb_post got=%h exp=0", bus.scoreboard_o); end
    n_vec++; if (dut.cnt_q !== 4'd0) begin n_err++; $display("FAIL ar_cnt_post got=%0d exp=0", dut.cnt_q); end
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    clr_id();
    bus.ex_flush_i     = 1'b0;
    bus.lsu_wb_valid_i = 1'b0;
    bus.lsu_wb_rd_i    = '0;
    bus.md_done_i      = 1'b0;
    bus.md_wb_rd_i     = '0;
    test_reset();
    test_load_use();
    test_load_fill();
    test_muldiv();
    test_flush();
    test_x0_waw();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
